pd_sched: RTL
=============

PD_SCHED -- requirements
Module: pd_sched

Interface
REQ-001 TIMEOUT_CYC, default 64, WAIT-state cycle limit per axis when PD_TIMEOUT_EN is defined; legal range 2..255.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 vld  input  1  single-cycle strobe: new inertial reading available.
REQ-005 inertial_cal  input  1  high during inertial calibration; scheduling suppressed.
REQ-006 pd_start  output  1  single-cycle launch strobe to the shared PD term unit.
REQ-007 pd_axis  output  2  axis being computed: 00 pitch, 01 roll, 10 yaw; 11 never driven.
REQ-008 pd_done  input  1  single-cycle strobe from PD unit: pterm_in/dterm_in valid.
REQ-009 pterm_in  input  10  signed P term for pd_axis.
REQ-010 dterm_in  input  12  signed D term for pd_axis.
REQ-011 ptch_pterm, roll_pterm, yaw_pterm  output  10 each  registered signed P terms.
REQ-012 ptch_dterm, roll_dterm, yaw_dterm  output  12 each  registered signed D terms.
REQ-013 terms_vld  output  1  single-cycle strobe: all six term registers updated from one reading.
REQ-014 overrun  output  1  sticky flag: vld arrived while a sequence was in progress.
REQ-015 timeout_err  output  1  sticky flag: PD unit failed to answer within TIMEOUT_CYC.

Function
REQ-016 FSM states SHALL be IDLE, LAUNCH, WAIT, DONE; encoding free.
REQ-017 IDLE: vld=1 and inertial_cal=0 -> LAUNCH with axis counter=00; otherwise stay.
REQ-018 LAUNCH: pd_start=1 for exactly this cycle; unconditional -> WAIT.
REQ-019 WAIT: pd_done=1 -> capture pterm_in/dterm_in into the register pair selected by axis counter; axis 10 -> DONE, else increment axis counter, -> LAUNCH.
REQ-020 DONE: terms_vld=1 for exactly this cycle; unconditional -> IDLE.
REQ-021 pd_axis SHALL equal the axis counter, stable from LAUNCH through the capturing WAIT cycle; 00 in IDLE.
REQ-022 pd_done outside WAIT SHALL be ignored (no capture, no transition).
REQ-023 Minimum latency: vld in cycle 0, pd_done one cycle after each pd_start -> terms_vld in cycle 7.
REQ-024 Term registers SHALL change only on a capture or on clear (REQ-026); values pass through unmodified, no saturation or sign extension.
REQ-025 vld while state != IDLE SHALL be dropped and set overrun; vld in the DONE cycle counts as overrun.
REQ-026 inertial_cal=1 in any state SHALL force -> IDLE next cycle, clear all six term registers to 0, suppress pd_start and terms_vld; flags unaffected.
REQ-027 vld and inertial_cal both high in IDLE: no launch, no overrun.
REQ-028 overrun and timeout_err SHALL clear only on reset.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, axis counter 00, all term registers 0, pd_start 0, terms_vld 0, overrun 0, timeout_err 0.
REQ-030 Reset mid-sequence SHALL abandon the sequence; a pd_done arriving after reset release is ignored per REQ-022.

Configuration
REQ-031 Macro PD_TIMEOUT_EN defined: an 8-bit wait counter clears on entry to WAIT and increments each WAIT cycle without pd_done; when it reaches TIMEOUT_CYC-1 without pd_done: -> IDLE, set timeout_err, no capture, no terms_vld, term registers retain prior values.
REQ-032 PD_TIMEOUT_EN undefined: no counter is built, WAIT waits indefinitely, and timeout_err is tied to 0; the port list does not change.

Verification
REQ-033 Reset, vld@0, pd_done 1 cycle after each start with pterm 0x005/0x3FB/0x100, dterm 0x00E/0xFF2/0x7E0 -> terms_vld@7, registers hold those values, pd_axis sequence 00,01,10.
REQ-034 vld during WAIT of roll -> overrun=1, sequence completes normally with one terms_vld.
REQ-035 inertial_cal raised during yaw WAIT -> IDLE next cycle, all terms 0, no terms_vld; later vld with cal=0 runs normally.
REQ-036 PD_TIMEOUT_EN, TIMEOUT_CYC=8, pd_done withheld on pitch -> return to IDLE after 8 WAIT cycles, timeout_err=1, terms unchanged; same stimulus without macro -> FSM stays in WAIT and timeout_err=0.
REQ-037 Stray pd_done in IDLE and LAUNCH with pterm 0x1FF -> no register change; rst_n pulsed mid-WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pd_sched.sv
// Sequences one shared PD term unit across pitch/roll/yaw for each inertial reading.
// Optional PD_TIMEOUT_EN macro adds a per-axis WAIT watchdog of TIMEOUT_CYC cycles.
module pd_sched #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vld,
  input  logic                inertial_cal,
  output logic                pd_start,
  output logic [1:0]          pd_axis,
  input  logic                pd_done,
  input  logic signed [9:0]   pterm_in,
  input  logic signed [11:0]  dterm_in,
  output logic signed [9:0]   ptch_pterm,
  output logic signed [9:0]   roll_pterm,
  output logic signed [9:0]   yaw_pterm,
  output logic signed [11:0]  ptch_dterm,
  output logic signed [11:0]  roll_dterm,
  output logic signed [11:0]  yaw_dterm,
  output logic                terms_vld,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int unsigned AW = 2;
  localparam int unsigned CW = 8;
  localparam logic [AW-1:0] AXIS_YAW = AW'(2);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   axis_nxt;
  logic            pd_start_nxt, terms_vld_nxt, overrun_nxt, timeout_nxt;
  logic            cap_c, tmo_hit_c;

`ifdef PD_TIMEOUT_EN
  logic [CW-1:0] wait_cnt;

  // Counts WAIT cycles without an answer; restarts on every launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         wait_cnt <= '0;
    else if (state == S_LAUNCH)         wait_cnt <= '0;
    else if (state == S_WAIT && !pd_done) wait_cnt <= wait_cnt + CW'(1);
  end

  assign tmo_hit_c = (state == S_WAIT) && !pd_done && !inertial_cal &&
                     (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
  // No watchdog: the parameter is only referenced to keep the interface uniform.
  assign tmo_hit_c = 1'b0 && (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (inertial_cal) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (vld) state_nxt = S_LAUNCH;
        S_LAUNCH: state_nxt = S_WAIT;
        S_WAIT: begin
          if (pd_done)        state_nxt = (pd_axis == AXIS_YAW) ? S_DONE : S_LAUNCH;
          else if (tmo_hit_c) state_nxt = S_IDLE;
        end
        S_DONE:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    cap_c         = !inertial_cal && (state == S_WAIT) && pd_done;
    pd_start_nxt  = (state_nxt == S_LAUNCH);
    terms_vld_nxt = (state_nxt == S_DONE);
    overrun_nxt   = overrun | (vld && (state != S_IDLE));
    timeout_nxt   = timeout_err | tmo_hit_c;
    axis_nxt      = pd_axis;
    if (state_nxt == S_IDLE)               axis_nxt = '0;
    else if (cap_c && pd_axis != AXIS_YAW) axis_nxt = pd_axis + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pd_start    <= 1'b0;
      terms_vld   <= 1'b0;
      pd_axis     <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      pd_start    <= pd_start_nxt;
      terms_vld   <= terms_vld_nxt;
      pd_axis     <= axis_nxt;
      overrun     <= overrun_nxt;
      timeout_err <= timeout_nxt;
    end
  end

  // Term registers: calibration clears, a capture loads the selected axis pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch_pterm <= '0; roll_pterm <= '0; yaw_pterm <= '0;
      ptch_dterm <= '0; roll_dterm <= '0; yaw_dterm <= '0;
    end else if (inertial_cal) begin
      ptch_pterm <= '0; roll_pterm <= '0; yaw_pterm <= '0;
      ptch_dterm <= '0; roll_dterm <= '0; yaw_dterm <= '0;
    end else if (cap_c) begin
      case (pd_axis)
        2'd0:    begin ptch_pterm <= pterm_in; ptch_dterm <= dterm_in; end
        2'd1:    begin roll_pterm <= pterm_in; roll_dterm <= dterm_in; end
        default: begin yaw_pterm  <= pterm_in; yaw_dterm  <= dterm_in; end
      endcase
    end
  end

endmodule
